// File: rtl/lz_matcher.sv
// Greedy nibble LZ matcher: 512-nibble history, emits literal / length / distance tokens.
// Optional feature macro LZ_MATCHER_STATS_EN adds saturating literal and match token counters.
module lz_matcher #(
    parameter int MAX_LEN   = 256,
    parameter int MIN_MATCH = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        data_in_vld,
    input  logic [3:0]  data_in,
    input  logic        data_in_last,
    output logic        data_in_rdy,
    output logic        data_out_vld,
    input  logic        data_out_rdy,
    output logic [4:0]  data_out,
    output logic [5:0]  ext_bits,
    output logic        data_out_last
`ifdef LZ_MATCHER_STATS_EN
    ,
    output logic [15:0] stat_lit,
    output logic [15:0] stat_match
`endif
);

    localparam logic [8:0] MAX_LEN_M1 = 9'(MAX_LEN - 1);
    localparam logic [8:0] MIN_M      = 9'(MIN_MATCH);

    typedef enum logic [2:0] {
        S_IDLE, S_CAND, S_EMIT_LIT, S_MATCH, S_EMIT_LEN, S_EMIT_DIST, S_EMIT_TAIL
    } state_t;

    state_t      r_state, w_next, w_after, w_end_state;

    logic [3:0]  r_hist [512];
    logic [8:0]  r_pos;
    logic [8:0]  r_lp_pos [16];
    logic [15:0] r_lp_vld;

    logic [3:0]  r_h;
    logic [8:0]  r_p, r_cand;
    logic        r_cand_vld, r_held_last, r_has_held, r_match_last;
    logic [8:0]  r_len, r_src, r_mstart, r_dist, r_tail_idx;

    logic        r_out_vld, r_out_last;
    logic [4:0]  r_out_data;
    logic [5:0]  r_out_ext;

    logic        w_accept, w_out_free, w_hit, w_match_end, w_start, w_last_hs, w_tail_final;
    logic [8:0]  w_dist, w_len_fin, w_tail_addr;
    logic        w_load, w_tok_last;
    logic [4:0]  w_tok;
    logic [5:0]  w_ext;

    // {code, ext}: largest length code whose offset does not exceed v
    function automatic logic [10:0] enc_len(input logic [8:0] v);
        logic [4:0] code;
        logic [8:0] off, diff;
        if      (v >= 9'd130) begin code = 5'd28; off = 9'd130; end
        else if (v >= 9'd64)  begin code = 5'd27; off = 9'd64;  end
        else if (v >= 9'd50)  begin code = 5'd26; off = 9'd50;  end
        else if (v >= 9'd34)  begin code = 5'd25; off = 9'd34;  end
        else if (v >= 9'd26)  begin code = 5'd24; off = 9'd26;  end
        else if (v >= 9'd22)  begin code = 5'd23; off = 9'd22;  end
        else if (v >= 9'd18)  begin code = 5'd22; off = 9'd18;  end
        else if (v >= 9'd14)  begin code = 5'd21; off = 9'd14;  end
        else if (v >= 9'd12)  begin code = 5'd20; off = 9'd12;  end
        else if (v >= 9'd10)  begin code = 5'd19; off = 9'd10;  end
        else if (v >= 9'd8)   begin code = 5'd18; off = 9'd8;   end
        else                  begin code = 5'd17; off = 9'd6;   end
        diff = v - off;
        return {code, diff[6:1]};
    endfunction

    function automatic logic [10:0] enc_dist(input logic [8:0] v);
        logic [4:0] code;
        logic [8:0] off, diff;
        if      (v >= 9'd450) begin code = 5'd15; off = 9'd450; end
        else if (v >= 9'd386) begin code = 5'd14; off = 9'd386; end
        else if (v >= 9'd322) begin code = 5'd13; off = 9'd322; end
        else if (v >= 9'd258) begin code = 5'd12; off = 9'd258; end
        else if (v >= 9'd194) begin code = 5'd11; off = 9'd194; end
        else if (v >= 9'd130) begin code = 5'd10; off = 9'd130; end
        else if (v >= 9'd66)  begin code = 5'd9;  off = 9'd66;  end
        else if (v >= 9'd34)  begin code = 5'd8;  off = 9'd34;  end
        else if (v >= 9'd26)  begin code = 5'd7;  off = 9'd26;  end
        else if (v >= 9'd18)  begin code = 5'd6;  off = 9'd18;  end
        else if (v >= 9'd14)  begin code = 5'd5;  off = 9'd14;  end
        else if (v >= 9'd10)  begin code = 5'd4;  off = 9'd10;  end
        else if (v >= 9'd8)   begin code = 5'd3;  off = 9'd8;   end
        else if (v >= 9'd6)   begin code = 5'd2;  off = 9'd6;   end
        else if (v >= 9'd4)   begin code = 5'd1;  off = 9'd4;   end
        else                  begin code = 5'd0;  off = 9'd2;   end
        diff = v - off;
        return {code, diff[6:1]};
    endfunction

    // A pending final token holds off the next stream until its handshake resets pos/last_pos.
    assign data_in_rdy  = en && ((r_state == S_IDLE && !(r_out_vld && r_out_last)) || r_state == S_MATCH);
    assign w_accept     = data_in_vld && data_in_rdy;
    assign w_out_free   = !r_out_vld || data_out_rdy;
    assign w_last_hs    = r_out_vld && data_out_rdy && r_out_last;
    assign w_hit        = (data_in == r_hist[r_src]);
    assign w_len_fin    = r_len + {8'd0, w_hit};
    assign w_match_end  = w_accept && (!w_hit || data_in_last || r_len == MAX_LEN_M1);
    assign w_dist       = r_p - r_cand;
    assign w_start      = r_cand_vld && !w_dist[0] && (w_dist != 9'd0);
    assign w_tail_addr  = r_mstart + r_tail_idx;
    assign w_tail_final = (r_tail_idx + 9'd1 == r_len);
    assign w_after      = r_has_held ? S_CAND : S_IDLE;
    assign w_end_state  = (w_len_fin >= MIN_M) ? S_EMIT_LEN : S_EMIT_TAIL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   r_state <= S_IDLE;
        else if (!en) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_tok      = '0;
        w_ext      = '0;
        w_tok_last = 1'b0;
        unique case (r_state)
            S_IDLE: if (w_accept) w_next = data_in_last ? S_EMIT_LIT : S_CAND;
            S_CAND: w_next = (!r_held_last && w_start) ? S_MATCH : S_EMIT_LIT;
            S_EMIT_LIT: if (w_out_free) begin
                w_load     = 1'b1;
                w_tok      = {1'b0, r_h};
                w_tok_last = r_held_last;
                w_next     = S_IDLE;
            end
            S_MATCH: if (w_match_end) w_next = w_end_state;
            S_EMIT_LEN: if (w_out_free) begin
                w_load         = 1'b1;
                {w_tok, w_ext} = enc_len({r_len[8:1], 1'b0});
                w_next         = S_EMIT_DIST;
            end
            S_EMIT_DIST: if (w_out_free) begin
                w_load         = 1'b1;
                {w_tok, w_ext} = enc_dist(r_dist);
                w_tok_last     = r_match_last && !r_len[0];
                w_next         = r_len[0] ? S_EMIT_TAIL : w_after;
            end
            S_EMIT_TAIL: if (w_out_free) begin
                w_load     = 1'b1;
                w_tok      = {1'b0, r_hist[w_tail_addr]};
                w_tok_last = r_match_last && w_tail_final;
                w_next     = w_tail_final ? w_after : S_EMIT_TAIL;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos      <= '0;
            r_lp_vld   <= '0;
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_ext  <= '0;
            r_out_last <= 1'b0;
        end else if (!en) begin
            r_pos      <= '0;
            r_lp_vld   <= '0;
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_ext  <= '0;
            r_out_last <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pos <= r_pos + 9'd1;
                for (int i = 0; i < 16; i++)
                    if (r_lp_vld[i] && r_lp_pos[i] == r_pos) r_lp_vld[i] <= 1'b0;
                r_lp_vld[data_in] <= 1'b1;
            end
            if (w_last_hs) begin
                r_pos    <= '0;
                r_lp_vld <= '0;
            end
            if (w_load) begin
                r_out_vld  <= 1'b1;
                r_out_data <= w_tok;
                r_out_ext  <= w_ext;
                r_out_last <= w_tok_last;
            end else if (data_out_rdy) begin
                r_out_vld  <= 1'b0;
            end
        end
    end

    // NOTE: history and match datapath carry no reset; each is written before it is read.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_hist[r_pos]     <= data_in;
            r_lp_pos[data_in] <= r_pos;
        end
        if (w_accept && (r_state == S_IDLE || !w_hit)) begin
            r_h         <= data_in;
            r_p         <= r_pos;
            r_cand      <= r_lp_pos[data_in];
            r_cand_vld  <= r_lp_vld[data_in];
            r_held_last <= data_in_last;
        end
        if (r_state == S_CAND) begin
            r_mstart <= r_p;
            r_dist   <= w_dist;
            r_len    <= 9'd1;
            r_src    <= r_cand + 9'd1;
        end
        if (r_state == S_MATCH && w_accept && w_hit) begin
            r_len <= w_len_fin;
            r_src <= r_src + 9'd1;
        end
        if (r_state == S_MATCH && w_match_end) begin
            r_match_last <= w_hit && data_in_last;
            r_has_held   <= !w_hit;
            r_tail_idx   <= (w_len_fin >= MIN_M) ? w_len_fin - 9'd1 : 9'd0;
        end
        if (r_state == S_EMIT_TAIL && w_out_free) r_tail_idx <= r_tail_idx + 9'd1;
    end

    assign data_out_vld  = r_out_vld;
    assign data_out      = r_out_data;
    assign ext_bits      = r_out_ext;
    assign data_out_last = r_out_last;

`ifdef LZ_MATCHER_STATS_EN
    logic        r_out_is_lit, r_out_is_len;
    logic [15:0] r_stat_lit, r_stat_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_is_lit <= 1'b0;
            r_out_is_len <= 1'b0;
            r_stat_lit   <= '0;
            r_stat_match <= '0;
        end else if (!en) begin
            r_out_is_lit <= 1'b0;
            r_out_is_len <= 1'b0;
            r_stat_lit   <= '0;
            r_stat_match <= '0;
        end else begin
            if (w_load) begin
                r_out_is_lit <= (r_state == S_EMIT_LIT) || (r_state == S_EMIT_TAIL);
                r_out_is_len <= (r_state == S_EMIT_LEN);
            end
            if (r_out_vld && data_out_rdy) begin
                if (r_out_is_lit && r_stat_lit != 16'hFFFF)   r_stat_lit   <= r_stat_lit + 16'd1;
                if (r_out_is_len && r_stat_match != 16'hFFFF) r_stat_match <= r_stat_match + 16'd1;
            end
        end
    end

    assign stat_lit   = r_stat_lit;
    assign stat_match = r_stat_match;
`endif

endmodule

// File: tb/tb_lz_matcher.sv
// Directed self-checking bench for lz_matcher: literal runs, long/short matches, back-pressure, abort.
module tb_lz_matcher;

    logic       clk = 1'b0;
    logic       rst_n, en;
    logic       data_in_vld, data_in_last, data_in_rdy;
    logic [3:0] data_in;
    logic       data_out_vld, data_out_rdy, data_out_last;
    logic [4:0] data_out;
    logic [5:0] ext_bits;
`ifdef LZ_MATCHER_STATS_EN
    logic [15:0] stat_lit, stat_match;
`endif

    lz_matcher dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .data_in_vld   (data_in_vld),
        .data_in       (data_in),
        .data_in_last  (data_in_last),
        .data_in_rdy   (data_in_rdy),
        .data_out_vld  (data_out_vld),
        .data_out_rdy  (data_out_rdy),
        .data_out      (data_out),
        .ext_bits      (ext_bits),
        .data_out_last (data_out_last)
`ifdef LZ_MATCHER_STATS_EN
        ,
        .stat_lit      (stat_lit),
        .stat_match    (stat_match)
`endif
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [11:0] got_q[$];
    logic [11:0] exp_q[$];
    logic [3:0]  in_q[$];

    // Tokens recorded as {last, ext, code} in the half-cycle before their handshake edge.
    always @(negedge clk)
        if (rst_n && en && data_out_vld && data_out_rdy)
            got_q.push_back({data_out_last, ext_bits, data_out});

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ex(input logic [4:0] code, input logic [5:0] ext, input logic last);
        exp_q.push_back({last, ext, code});
    endtask

    // Sends in_q with last on the final nibble when with_last is set; called on a falling edge.
    task automatic drive(input bit with_last);
        for (int i = 0; i < in_q.size(); i++) begin
            int t = 0;
            data_in      = in_q[i];
            data_in_last = with_last && (i == in_q.size() - 1);
            data_in_vld  = 1'b1;
            while (!data_in_rdy && t < 300) begin
                @(negedge clk);
                t++;
            end
            if (t >= 300) check("input accept timeout", 32'(t), 32'd0);
            @(negedge clk);
        end
        data_in_vld  = 1'b0;
        data_in_last = 1'b0;
    endtask

    task automatic check_stream(input string tag);
        int t = 0;
        while (got_q.size() < exp_q.size() && t < 2000) begin
            @(negedge clk);
            t++;
        end
        repeat (10) @(negedge clk);
        check({tag, " token count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size())
                check($sformatf("%s tok%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic exp_test2();
        ex(5'd1, 6'd0, 1'b0);
        ex(5'd2, 6'd0, 1'b0);
        ex(5'd18, 6'd0, 1'b0);
        ex(5'd0, 6'd0, 1'b1);
    endtask

    task automatic load_test1();
        in_q.delete();
        for (int i = 0; i < 16; i++) begin
            in_q.push_back(4'(i));
            ex(5'(i), 6'd0, i == 15);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        en           = 1'b1;
        data_in_vld  = 1'b0;
        data_in      = 4'd0;
        data_in_last = 1'b0;
        data_out_rdy = 1'b1;
        repeat (3) @(negedge clk);
        check("reset vld",  32'(data_out_vld),  32'd0);
        check("reset data", 32'(data_out),      32'd0);
        check("reset ext",  32'(ext_bits),      32'd0);
        check("reset last", 32'(data_out_last), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle rdy", 32'(data_in_rdy), 32'd1);

        // 1: sixteen distinct nibbles, all literals
        load_test1();
        drive(1'b1);
        check_stream("t1");
`ifdef LZ_MATCHER_STATS_EN
        check("t1 stat_lit",   32'(stat_lit),   32'd16);
        check("t1 stat_match", 32'(stat_match), 32'd0);
`endif

        // 2: repeating pair gives an 8-long match at distance 2
        in_q = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd1, 4'd2, 4'd1, 4'd2, 4'd1, 4'd2};
        exp_test2();
        drive(1'b1);
        check_stream("t2");

        // 3: match of length 3 is too short and is replayed as literals
        in_q = '{4'd5, 4'd6, 4'd5, 4'd6, 4'd5, 4'd9};
        ex(5'd5, 6'd0, 1'b0);
        ex(5'd6, 6'd0, 1'b0);
        ex(5'd5, 6'd0, 1'b0);
        ex(5'd6, 6'd0, 1'b0);
        ex(5'd5, 6'd0, 1'b0);
        ex(5'd9, 6'd0, 1'b1);
        drive(1'b1);
        check_stream("t3");

        // 4: odd match length 7 -> len 6, dist 2, trailing literal, then the miss nibble
        in_q = '{4'd3, 4'd4, 4'd3, 4'd4, 4'd3, 4'd4, 4'd3, 4'd4, 4'd3, 4'd7};
        ex(5'd3, 6'd0, 1'b0);
        ex(5'd4, 6'd0, 1'b0);
        ex(5'd17, 6'd0, 1'b0);
        ex(5'd0, 6'd0, 1'b0);
        ex(5'd3, 6'd0, 1'b0);
        ex(5'd7, 6'd0, 1'b1);
        drive(1'b1);
        check_stream("t4");

        // 5: stream 2 again with the consumer stalled on the LEN token
        in_q = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd1, 4'd2, 4'd1, 4'd2, 4'd1, 4'd2};
        exp_test2();
        fork
            drive(1'b1);
            begin
                int  t    = 0;
                bit  seen = 1'b0;
                while (!seen && t < 500) begin
                    @(posedge clk);
                    #1;
                    if (data_out_vld && data_out == 5'd18) seen = 1'b1;
                    t++;
                end
                data_out_rdy = 1'b0;
                check("t5 len token seen", 32'(seen), 32'd1);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("t5 stall vld",  32'(data_out_vld), 32'd1);
                    check("t5 stall data", 32'(data_out),     32'd18);
                    check("t5 stall ext",  32'(ext_bits),     32'd0);
                    check("t5 stall rdy",  32'(data_in_rdy),  32'd0);
                end
                data_out_rdy = 1'b1;
            end
        join
        check_stream("t5");

        // 6: abort mid-match, then an independent fresh stream
        in_q = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd1};
        drive(1'b0);
        repeat (3) @(negedge clk);
        check("t6 in match rdy", 32'(data_in_rdy), 32'd1);
        en = 1'b0;
        #1;
        check("t6 en low rdy", 32'(data_in_rdy), 32'd0);
        @(posedge clk);
        #1;
        check("t6 vld after abort",  32'(data_out_vld), 32'd0);
        check("t6 data after abort", 32'(data_out),     32'd0);
        @(negedge clk);
        en = 1'b1;
        got_q.delete();
        @(negedge clk);
        check("t6 idle rdy", 32'(data_in_rdy), 32'd1);
        load_test1();
        drive(1'b1);
        check_stream("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
